// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point exponent/mantissa control path:
// scheduler state encoding and frame counter sizing.
package bfp_pkg;
  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  localparam int LANES         = 2;
  localparam int FRAME_LEN_DEF = 8;
  localparam int CNT_W         = $clog2(FRAME_LEN_DEF + 1);

  // Counter must hold the value FRAME_LEN itself, not just FRAME_LEN-1.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction
endpackage

// File: rtl/bfp_exp_scheduler_max3.sv
// Combinational three-way unsigned max: running frame max against both lanes of a pair.
module exp_max3 #(
  parameter int W = 3
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_max
);
  logic [W-1:0] w_ab;

  assign w_ab  = (i_a > i_b) ? i_a : i_b;
  assign o_max = (w_ab > i_c) ? w_ab : i_c;
endmodule

// File: rtl/bfp_exp_scheduler.sv
// Frame-level block-exponent scheduler: buffers a frame of exponent pairs, tracks the
// frame max, then replays the frame as per-lane right-shift offsets (max - exp).
module bfp_exp_scheduler
  import bfp_pkg::*;
#(
  parameter int expWidth  = 3,
  parameter int FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*expWidth-1:0] in_exp,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*expWidth-1:0] out_offset,
  output logic [expWidth-1:0]   out_max_exp,
  output logic                  out_last,
  output logic                  busy
);
  localparam int CW = cnt_width(FRAME_LEN);
  localparam int AW = $clog2(FRAME_LEN);

  typedef logic [LANES-1:0][expWidth-1:0] pair_t;

  state_t              r_state;
  pair_t               r_buf [FRAME_LEN];
  logic [CW-1:0]       r_wr_cnt, r_rd_cnt, r_n;
  logic [expWidth-1:0] r_run_max, r_max;
  logic                r_out_vld, r_out_last, r_busy;
  pair_t               r_out_off;
  logic [expWidth-1:0] r_out_max;

  pair_t               w_in, w_first, w_next, w_off_first, w_off_next;
  logic [expWidth-1:0] w_max;
  logic [CW-1:0]       w_wr_nxt, w_rd_nxt;
  logic                w_accept, w_close;

  assign in_ready = (r_state == COLLECT);
  assign w_in     = in_exp;
  assign w_accept = in_valid && in_ready;
  assign w_wr_nxt = r_wr_cnt + CW'(1);
  assign w_rd_nxt = r_rd_cnt + CW'(1);
  assign w_close  = w_accept && (in_last || (w_wr_nxt == CW'(FRAME_LEN)));

  exp_max3 #(.W(expWidth)) u_max3 (
    .i_a   (r_run_max),
    .i_b   (w_in[0]),
    .i_c   (w_in[1]),
    .o_max (w_max)
  );

  // Entry 0 is being written on the closing beat of a single-beat frame; bypass it.
  assign w_first = (r_wr_cnt == '0) ? w_in : r_buf[0];
  assign w_next  = r_buf[w_rd_nxt[AW-1:0]];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_off_first[k] = w_max - w_first[k];
    assign w_off_next[k]  = r_max - w_next[k];
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_cnt[AW-1:0]] <= w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= COLLECT;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_n        <= '0;
      r_run_max  <= '0;
      r_max      <= '0;
      r_out_vld  <= 1'b0;
      r_out_off  <= '0;
      r_out_max  <= '0;
      r_out_last <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_wr_cnt  <= w_wr_nxt;
            r_run_max <= w_max;
          end
          if (w_close) begin
            r_n        <= w_wr_nxt;
            r_max      <= w_max;
            r_rd_cnt   <= '0;
            r_out_vld  <= 1'b1;
            r_out_off  <= w_off_first;
            r_out_max  <= w_max;
            r_out_last <= (w_wr_nxt == CW'(1));
            r_busy     <= 1'b1;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_wr_cnt   <= '0;
              r_rd_cnt   <= '0;
              r_run_max  <= '0;
              r_out_vld  <= 1'b0;
              r_out_off  <= '0;
              r_out_max  <= '0;
              r_out_last <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= COLLECT;
            end else begin
              r_rd_cnt   <= w_rd_nxt;
              r_out_off  <= w_off_next;
              r_out_last <= (w_rd_nxt == r_n - CW'(1));
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign out_valid   = r_out_vld;
  assign out_offset  = r_out_off;
  assign out_max_exp = r_out_max;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
endmodule
